// File: rtl/fpadd_arbiter.sv
// fpadd_arbiter
// -------------
// Shares one pipelined floating-point adder between NREQ requesters.
// At most one requester is granted per cycle. The granted operands go to the
// adder combinationally in the grant cycle. A LAT-deep tag pipeline of
// {valid, requester index} follows each operation through the adder, so the
// adder output can be steered back to the requester that issued it.
//
// Build option:
//   FPADD_ARB_RR_EN  defined   -> round-robin arbitration. The search starts
//                                 after the last granted index.
//                    undefined -> fixed priority. The lowest index wins and
//                                 there is no pointer register.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   req_valid[NREQ]     per-requester operation valid
//   req_ready[NREQ]     one-hot grant (transfer when valid & ready)
//   req_a, req_b        packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op[NREQ]        per-requester op, 0 = add, 1 = sub
//   fpa_a, fpa_b        operands to the adder (0 when nothing is issued)
//   fpa_op              op to the adder, delayed by one cycle
//   fpa_ce              adder clock enable (low only in reset)
//   fpa_z               adder result
//   res_valid[NREQ]     one-hot single-cycle result strobe
//   res_z               result data (equal to fpa_z)
//   drain               stop issuing new operations
//   drain_done          draining and nothing in flight
//   busy                any operation in flight
module fpadd_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int LAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_op,
    output logic [WIDTH-1:0]      fpa_a,
    output logic [WIDTH-1:0]      fpa_b,
    output logic                  fpa_op,
    output logic                  fpa_ce,
    input  logic [WIDTH-1:0]      fpa_z,
    output logic [NREQ-1:0]       res_valid,
    output logic [WIDTH-1:0]      res_z,
    input  logic                  drain,
    output logic                  drain_done,
    output logic                  busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t          state_reg;
    logic            op_reg;
    logic [LAT-1:0]  tag_valid_reg;
    logic [IDXW-1:0] tag_idx_reg [LAT];

    logic            grant_any;
    logic [IDXW-1:0] grant_idx;
    logic            transfer;

`ifdef FPADD_ARB_RR_EN
    logic [IDXW-1:0] ptr_reg;

    // Search from the requester after the last grant, wrapping around. The
    // last candidate (k == NREQ) is the previous winner itself.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_any && req_valid[(int'(ptr_reg) + k) % NREQ]) begin
                grant_any = 1'b1;
                grant_idx = IDXW'((int'(ptr_reg) + k) % NREQ);
            end
        end
    end
`else
    // Fixed priority: the lowest valid index wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && req_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = IDXW'(k);
            end
        end
    end
`endif

    // rst_n gates the grant so that req_ready stays low during reset, even
    // while requesters hold valid.
    assign transfer = grant_any && rst_n && (state_reg == RUN);

    // The adder registers its operands itself, so they are driven straight
    // from the winning slice. They are zero when nothing is issued.
    assign fpa_a = transfer ? req_a[grant_idx*WIDTH +: WIDTH] : '0;
    assign fpa_b = transfer ? req_b[grant_idx*WIDTH +: WIDTH] : '0;

    // The adder does not register op. It has to arrive one cycle after the
    // operands.
    assign fpa_op = op_reg;
    assign fpa_ce = rst_n;

    // Control FSM. The drain request is registered, so a grant made in the
    // cycle where drain first rises still goes through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            op_reg    <= 1'b0;
`ifdef FPADD_ARB_RR_EN
            ptr_reg   <= IDXW'(NREQ - 1);
`endif
        end else begin
            case (state_reg)
                RUN:     if (drain)  state_reg <= DRAIN;
                DRAIN:   if (!drain) state_reg <= RUN;
                default:             state_reg <= RUN;
            endcase
            op_reg <= transfer ? req_op[grant_idx] : 1'b0;
`ifdef FPADD_ARB_RR_EN
            if (transfer) ptr_reg <= grant_idx;
`endif
        end
    end

    // Tag pipeline. Only the valid bits need a reset. Stale indices are
    // harmless because res_valid is qualified by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_reg <= '0;
        end else begin
            tag_valid_reg[0] <= transfer;
            for (int i = 1; i < LAT; i++) tag_valid_reg[i] <= tag_valid_reg[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_idx_reg[0] <= grant_idx;
        for (int i = 1; i < LAT; i++) tag_idx_reg[i] <= tag_idx_reg[i-1];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_port
            assign req_ready[gi] = transfer && (grant_idx == IDXW'(gi));
            assign res_valid[gi] = tag_valid_reg[LAT-1] &&
                                   (tag_idx_reg[LAT-1] == IDXW'(gi));
        end
    endgenerate

    assign res_z      = fpa_z;
    assign busy       = |tag_valid_reg;
    assign drain_done = (state_reg == DRAIN) && !busy;

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Scoreboard bench for fpadd_arbiter. A behavioural two-stage adder sits on
// the fpa_* ports. The stimulus pushes the expected {index, result, cycle}
// whenever a grant is expected, and a monitor pops and compares on res_valid.
module tb_fpadd_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int LAT  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_op;
    logic [W-1:0]      fpa_a;
    logic [W-1:0]      fpa_b;
    logic              fpa_op;
    logic              fpa_ce;
    logic [W-1:0]      fpa_z;
    logic [NREQ-1:0]   res_valid;
    logic [W-1:0]      res_z;
    logic              drain;
    logic              drain_done;
    logic              busy;

    always #5 clk = ~clk;

    fpadd_arbiter #(.NREQ(NREQ), .WIDTH(W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_op(fpa_op), .fpa_ce(fpa_ce),
        .fpa_z(fpa_z),
        .res_valid(res_valid), .res_z(res_z),
        .drain(drain), .drain_done(drain_done), .busy(busy)
    );

    // Conversions between single precision and real. Normal numbers only.
    function automatic real f2r(logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        d = {f[31], e, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Adder model: operands are registered, op is applied one cycle later,
    // and the result is registered. The total latency is 2 cycles.
    logic [31:0] a1, b1, z_reg;
    always @(posedge clk) begin
        if (fpa_ce) begin
            a1    <= fpa_a;
            b1    <= fpa_b;
            z_reg <= fpa_op ? r2f(f2r(a1) - f2r(b1)) : r2f(f2r(a1) + f2r(b1));
        end
    end
    assign fpa_z = z_reg;

    typedef struct {
        int          idx;
        logic [31:0] z;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && res_valid != '0) begin
            if (sb.size() == 0) begin
                chk("res_unexpected", 64'(res_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                $display("result idx=%0d z=%h cyc=%0d", e.idx, res_z, cyc);
                chk("res_valid", 64'(res_valid), 64'(1 << e.idx));
                chk("res_z", 64'(res_z), 64'(e.z));
                chk("res_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic [31:0] a, logic [31:0] b, logic op);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_op[i]       = op;
    endtask

    // Check the grant at the sample edge. If a grant is expected, check the
    // operand path and queue the expected result.
    task automatic cycle_check(logic [NREQ-1:0] exp_ready, int idx);
        logic [31:0] a, b, z;
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        if (exp_ready != '0) begin
            a = req_a[idx*W +: W];
            b = req_b[idx*W +: W];
            z = req_op[idx] ? r2f(f2r(a) - f2r(b)) : r2f(f2r(a) + f2r(b));
            chk("fpa_a", 64'(fpa_a), 64'(a));
            chk("fpa_b", 64'(fpa_b), 64'(b));
            sb.push_back('{idx: idx, z: z, cyc: cyc + LAT});
            $display("issue idx=%0d a=%h b=%h op=%0d cyc=%0d", idx, a, b, req_op[idx], cyc);
        end else begin
            chk("fpa_a_idle", 64'(fpa_a), 64'd0);
        end
    endtask

    task automatic idle(int n);
        req_valid = '0;
        repeat (n) begin
            cycle_check('0, 0);
            next();
        end
    endtask

    task automatic reset_outputs(string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_drain_done"}, 64'(drain_done), 64'd0);
        chk({tag, "_fpa_ce"}, 64'(fpa_ce), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drain     = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) set_req(i, r2f(real'(i + 1)), r2f(2.0), 1'b0);

        // Reset holds every output quiet, even while all requesters are valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_outputs("rst");
        chk("rst_fpa_a", 64'(fpa_a), 64'd0);
        chk("rst_fpa_op", 64'(fpa_op), 64'd0);

        // Contention with all requesters valid from reset.
        next();
        rst_n = 1'b1;
`ifdef FPADD_ARB_RR_EN
        for (int k = 0; k < 5; k++) begin
            cycle_check(NREQ'(1 << (k % NREQ)), k % NREQ);
            next();
        end
`else
        req_valid = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            cycle_check(4'b0001, 0);
            next();
        end
        req_valid = 4'b0010;
        cycle_check(4'b0010, 1);
        next();
`endif
        idle(4);

        // Single requester: 1.0 + 2.0 = 3.0 (0x40400000).
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
        req_valid = 4'b0001;
        cycle_check(4'b0001, 0);
        chk("t1_busy_T", 64'(busy), 64'd0);
        next();
        req_valid = '0;
        cycle_check('0, 0);
        chk("t1_busy_T1", 64'(busy), 64'd1);
        chk("t1_op", 64'(fpa_op), 64'd0);
        next();
        cycle_check('0, 0);
        chk("t1_busy_T2", 64'(busy), 64'd1);
        next();
        cycle_check('0, 0);
        chk("t1_busy_T3", 64'(busy), 64'd0);
        next();

        // Sub followed immediately by an add on requester 2.
        set_req(2, 32'h40400000, 32'h3F800000, 1'b1);
        req_valid = 4'b0100;
        cycle_check(4'b0100, 2);
        next();
        set_req(2, r2f(5.0), r2f(0.5), 1'b0);
        cycle_check(4'b0100, 2);
        chk("t2_op_sub", 64'(fpa_op), 64'd1);
        next();
        req_valid = '0;
        cycle_check('0, 0);
        chk("t2_op_add", 64'(fpa_op), 64'd0);
        next();
        idle(3);

        // Drain with two operations in flight. The grant in the cycle where
        // drain rises is still honoured.
        set_req(0, r2f(1.5), r2f(2.25), 1'b0);
        set_req(1, r2f(8.0), r2f(3.0), 1'b1);
        set_req(3, r2f(1.0), r2f(1.0), 1'b0);
        req_valid = 4'b0001;
        cycle_check(4'b0001, 0);
        next();
        req_valid = 4'b0010;
        drain = 1'b1;
        cycle_check(4'b0010, 1);
        next();
        req_valid = 4'b1000;
        cycle_check('0, 0);
        chk("dr_done_a", 64'(drain_done), 64'd0);
        next();
        cycle_check('0, 0);
        chk("dr_done_b", 64'(drain_done), 64'd0);
        next();
        cycle_check('0, 0);
        chk("dr_done_c", 64'(drain_done), 64'd1);
        chk("dr_busy", 64'(busy), 64'd0);
        next();
        drain = 1'b0;
        cycle_check('0, 0);
        chk("dr_done_d", 64'(drain_done), 64'd1);
        next();
        cycle_check(4'b1000, 3);
        next();
        idle(3);

        // Reset one cycle after an issue. The issued op must never report.
        set_req(0, r2f(4.0), r2f(4.0), 1'b0);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("rm_grant", 64'(req_ready), 64'(4'b0001));
        next();
        req_valid = '1;
        rst_n = 1'b0;
        @(negedge clk);
        reset_outputs("rm");
        next();
        req_valid = '0;
        rst_n = 1'b1;
        idle(5);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fpadd_arbiter.md
FPADD_ARBITER -- requirements
Module: fpadd_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-003 SHALL have parameter LAT, default 2: adder latency in cycles, from operand drive to FP_Z valid.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NREQ  per-requester operation valid.
REQ-007 req_ready  out  NREQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 req_a, req_b  in  NREQ*WIDTH  packed operands; requester i uses slice [i*WIDTH +: WIDTH].
REQ-009 req_op  in  NREQ  per-requester op: 0 = add, 1 = sub.
REQ-010 fpa_a, fpa_b  out  WIDTH  operands to the adder FP_A and FP_B ports.
REQ-011 fpa_op  out  1  op to the adder.
REQ-012 fpa_ce  out  1  adder clock enable.
REQ-013 fpa_z  in  WIDTH  adder result (FP_Z).
REQ-014 res_valid  out  NREQ  one-hot, single-cycle result strobe; no backpressure.
REQ-015 res_z  out  WIDTH  result data, equal to fpa_z.
REQ-016 drain  in  1  stop issuing new operations.
REQ-017 drain_done  out  1  high while draining and no operation is in flight.
REQ-018 busy  out  1  high while any operation is in flight.

Function
REQ-019 SHALL grant at most one requester per cycle; req_ready is combinational from req_valid, arbitration state and FSM state.
REQ-020 On transfer in cycle T, fpa_a and fpa_b SHALL carry the granted operands combinationally in cycle T.
REQ-021 When there is no transfer, fpa_a and fpa_b SHALL be 0.
REQ-022 The adder registers its operands but not op, so fpa_op SHALL be the registered req_op of the operation issued in T-1, and 0 if that slot was empty.
REQ-023 fpa_ce SHALL be 0 in reset and 1 at all other times; the pipeline never stalls.
REQ-024 SHALL keep a LAT-deep tag shift register of {valid, requester index}, advanced every cycle.
REQ-025 A tag entering at T SHALL exit at T+LAT.
REQ-026 res_valid[idx] SHALL be high in cycle T+LAT exactly when the exiting tag is valid; res_z SHALL equal fpa_z.
REQ-027 Results SHALL return in issue order.
REQ-028 Throughput SHALL be one operation per cycle.
REQ-029 busy SHALL equal the OR of the valid bits of all tags.
REQ-030 FSM has two states, RUN and DRAIN.
REQ-031 RUN -> DRAIN when drain = 1; DRAIN -> RUN when drain = 0.
REQ-032 In DRAIN, req_ready SHALL be all zeros; in-flight operations SHALL complete normally.
REQ-033 drain_done SHALL equal (state == DRAIN) and not busy.
REQ-034 drain sampled high in cycle T SHALL block grants from cycle T+1; a grant made in T is honoured.
REQ-035 A requester deasserting req_valid without being granted SHALL lose nothing; its pending request is simply withdrawn.

Reset
REQ-036 While rst_n = 0, all tag valid bits SHALL clear, state = RUN, the round-robin pointer = NREQ-1, and the registered op = 0.
REQ-037 While rst_n = 0, outputs SHALL be req_ready = 0, res_valid = 0, busy = 0, drain_done = 0 and fpa_ce = 0.
REQ-038 Operations in flight at reset SHALL be discarded; no res_valid is produced for them after reset release.

Configuration
REQ-039 Macro FPADD_ARB_RR_EN defined: round-robin arbitration. The search starts at pointer+1 modulo NREQ, and the pointer updates to the granted index on each transfer.
REQ-040 Macro FPADD_ARB_RR_EN undefined: fixed priority, lowest index wins; no pointer register is implemented.

Verification
REQ-041 Single requester: req 0 issues 0x3F800000 + 0x40000000 with op = 0 at T -> res_valid = 4'b0001 and res_z = 0x40400000 at T+2, and busy is high in T+1 and T+2.
REQ-042 Sub op alignment: req 2 issues 0x40400000 - 0x3F800000 with op = 1, then an add issues in the next cycle -> results 0x40000000, then the correct sum, on consecutive cycles to index 2.
REQ-043 Contention (RR_EN defined): all four requesters valid continuously from reset -> grants 0, 1, 2, 3, 0 on consecutive cycles, and res_valid follows the same order 2 cycles later.
REQ-044 Contention (RR_EN undefined): requesters 0 and 1 valid continuously -> req 1 is never granted, and req 1 is granted the cycle after req 0 drops.
REQ-045 Drain: drain raised while 2 operations are in flight -> no new grants, both results return, and drain_done rises the cycle after the last res_valid; lowering drain resumes grants.
REQ-046 Reset mid-operation: rst_n pulsed low 1 cycle after an issue -> no res_valid ever appears for that operation, and all outputs are at their reset values during reset.
